// File: rtl/simon128_engine_if.sv
// Data bundle between the Simon 128/128 engine and its driver: plaintext/key in,
// round key, state and completion flag out.
interface simon128_engine_if;
    logic [127:0] pt_i;
    logic [127:0] k0_i;
    logic [63:0]  kj_o;
    logic [127:0] ct_o;
    logic         done_o;

    modport master (
        output pt_i,
        output k0_i,
        input  kj_o,
        input  ct_o,
        input  done_o
    );

    modport slave (
        input  pt_i,
        input  k0_i,
        output kj_o,
        output ct_o,
        output done_o
    );
endinterface

// File: rtl/simon128_engine.sv
// Iterative Simon 128/128 encryption: one Feistel round per clock with the key
// schedule expanded on the fly; one encryption per reset release.
module simon128_engine (
    input  logic              clk,
    input  logic              rst_n,
    simon128_engine_if.slave  bus
);
    // z2 with z[0] at bit 61; padded so the 6-bit index never leaves the vector
    localparam logic [63:0] Z2      = {2'b00, 62'b10101111011100000011010010011000101000010001111110010110110011};
    localparam logic [63:0] C_CONST = 64'hFFFF_FFFF_FFFF_FFFC;
    localparam logic [6:0]  LAST_RD = 7'd68;

    logic [63:0] r_x;
    logic [63:0] r_y;
    logic [63:0] r_ka;
    logic [63:0] r_kb;
    logic [6:0]  r_cnt;
    logic        r_done;

    logic [63:0] w_f;
    logic [63:0] w_x_next;
    logic [63:0] w_kb_next;
    logic [6:0]  w_round;
    logic [5:0]  w_zidx;
    logic [5:0]  w_zpos;
    logic        w_zbit;

    assign w_f      = ({r_x[62:0], r_x[63]} & {r_x[55:0], r_x[63:56]}) ^ {r_x[61:0], r_x[63:62]};
    assign w_x_next = r_y ^ w_f ^ r_ka;

    // Rounds 62..67 wrap back to the start of z2
    assign w_round = r_cnt - 7'd1;
    assign w_zidx  = (w_round >= 7'd62) ? 6'(w_round - 7'd62) : w_round[5:0];
    assign w_zpos  = 6'd61 - w_zidx;
    assign w_zbit  = Z2[w_zpos];

    assign w_kb_next = C_CONST ^ {63'd0, w_zbit} ^ r_ka
                     ^ {r_kb[2:0], r_kb[63:3]} ^ {r_kb[3:0], r_kb[63:4]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x    <= '0;
            r_y    <= '0;
            r_ka   <= '0;
            r_kb   <= '0;
            r_cnt  <= '0;
            r_done <= 1'b0;
        end else if (r_cnt == 7'd0) begin
            r_x   <= bus.pt_i[127:64];
            r_y   <= bus.pt_i[63:0];
            r_ka  <= bus.k0_i[63:0];
            r_kb  <= bus.k0_i[127:64];
            r_cnt <= 7'd1;
        end else if (r_cnt <= LAST_RD) begin
            r_x    <= w_x_next;
            r_y    <= r_x;
            r_ka   <= r_kb;
            r_kb   <= w_kb_next;
            r_cnt  <= r_cnt + 7'd1;
            r_done <= (r_cnt == LAST_RD);
        end
    end

    assign bus.kj_o   = r_ka;
    assign bus.ct_o   = {r_x, r_y};
    assign bus.done_o = r_done;
endmodule

// File: tb/tb_simon128_engine.sv
// Directed bench for simon128_engine: standard vector, reset/abort behaviour,
// hold after completion, and a cycle-by-cycle comparison on an all-zero input.
module tb_simon128_engine;
    localparam logic [127:0] STD_KEY = 128'h0f0e0d0c0b0a0908_0706050403020100;
    localparam logic [127:0] STD_PT  = 128'h63736564_20737265_6c6c6576_61727420;
    localparam logic [127:0] STD_CT  = 128'h49681b1e1e54fe3f_65aa832af84e0bbc;
    localparam logic [63:0]  KC      = 64'hFFFF_FFFF_FFFF_FFFC;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    simon128_engine_if bus ();

    simon128_engine dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] rotl(input logic [63:0] v, input int n);
        return (v << n) | (v >> (64 - n));
    endfunction

    function automatic logic [63:0] rotr(input logic [63:0] v, input int n);
        return (v >> n) | (v << (64 - n));
    endfunction

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic assert_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
    endtask

    string       z2_str;
    logic [63:0] mk [0:69];
    logic [63:0] mx;
    logic [63:0] my;
    logic [63:0] tmp;

    initial begin
        clk      = 1'b0;
        rst_n    = 1'b1;
        n_checks = 0;
        n_errors = 0;
        z2_str   = "10101111011100000011010010011000101000010001111110010110110011";
        bus.pt_i = {$urandom, $urandom, $urandom, $urandom};
        bus.k0_i = {$urandom, $urandom, $urandom, $urandom};

        // Reset values with random inputs present
        #2 rst_n = 1'b0;
        repeat (3) tick();
        check("reset ct_o", bus.ct_o, 128'd0);
        check("reset kj_o", {64'd0, bus.kj_o}, 128'd0);
        check("reset done_o", {127'd0, bus.done_o}, 128'd0);

        // Standard vector
        bus.pt_i = STD_PT;
        bus.k0_i = STD_KEY;
        release_reset();
        tick();
        check("load ct_o", bus.ct_o, STD_PT);
        check("load kj_o", {64'd0, bus.kj_o}, {64'd0, 64'h0706050403020100});
        check("load done_o", {127'd0, bus.done_o}, 128'd0);
        tick();
        check("round0 y", {64'd0, bus.ct_o[63:0]}, {64'd0, 64'h6373656420737265});
        check("round0 kj_o", {64'd0, bus.kj_o}, {64'd0, 64'h0f0e0d0c0b0a0908});
        repeat (66) tick();
        check("edge68 done_o", {127'd0, bus.done_o}, 128'd0);
        tick();
        check("std ct_o", bus.ct_o, STD_CT);
        check("std done_o", {127'd0, bus.done_o}, 128'd1);

        // Hold after DONE while inputs change
        for (int c = 0; c < 20; c++) begin
            bus.pt_i = {$urandom, $urandom, $urandom, $urandom};
            bus.k0_i = {$urandom, $urandom, $urandom, $urandom};
            tick();
        end
        check("hold ct_o", bus.ct_o, STD_CT);
        check("hold done_o", {127'd0, bus.done_o}, 128'd1);

        // Mid-operation abort at edge 30, inputs disturbed after LOAD
        assert_reset();
        bus.pt_i = STD_PT;
        bus.k0_i = STD_KEY;
        release_reset();
        tick();
        bus.pt_i = ~STD_PT;
        bus.k0_i = ~STD_KEY;
        repeat (29) tick();
        rst_n = 1'b0;
        #1;
        check("abort ct_o", bus.ct_o, 128'd0);
        check("abort kj_o", {64'd0, bus.kj_o}, 128'd0);
        check("abort done_o", {127'd0, bus.done_o}, 128'd0);
        bus.pt_i = STD_PT;
        bus.k0_i = STD_KEY;
        release_reset();
        tick();
        bus.pt_i = {$urandom, $urandom, $urandom, $urandom};
        bus.k0_i = {$urandom, $urandom, $urandom, $urandom};
        repeat (68) tick();
        check("restart ct_o", bus.ct_o, STD_CT);
        check("restart done_o", {127'd0, bus.done_o}, 128'd1);

        // All-zero key/plaintext against a software model, every cycle
        mk[0] = 64'd0;
        mk[1] = 64'd0;
        for (int i = 0; i < 68; i++) begin
            tmp       = rotr(mk[i + 1], 3);
            mk[i + 2] = KC ^ {63'd0, (z2_str[i % 62] == "1")} ^ mk[i] ^ tmp ^ rotr(tmp, 1);
        end
        mx = 64'd0;
        my = 64'd0;
        assert_reset();
        bus.pt_i = 128'd0;
        bus.k0_i = 128'd0;
        release_reset();
        tick();
        check("zero load ct_o", bus.ct_o, {mx, my});
        check("zero load kj_o", {64'd0, bus.kj_o}, {64'd0, mk[0]});
        for (int r = 0; r < 68; r++) begin
            tmp = my ^ ((rotl(mx, 1) & rotl(mx, 8)) ^ rotl(mx, 2)) ^ mk[r];
            my  = mx;
            mx  = tmp;
            tick();
            check($sformatf("zero r%0d ct_o", r), bus.ct_o, {mx, my});
            check($sformatf("zero r%0d kj_o", r), {64'd0, bus.kj_o}, {64'd0, mk[r + 1]});
        end
        check("zero done_o", {127'd0, bus.done_o}, 128'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
